// File: rtl/nibble_mayor_driver_if.sv
// Comparator bus between the nibble-max sweep driver and the comparator under test.
//   nd_a, nd_b : operand pair presented to the comparator (nm2_a / nm2_b)
//   nd_valid   : high while nd_a/nd_b carry a pair of the current sweep
//   nd_mayor   : comparator result (nm2_mayor), returned after the comparator latency
// master = driver side, slave = comparator side.
interface nibble_mayor_driver_if;
  logic [3:0] nd_a;
  logic [3:0] nd_b;
  logic       nd_valid;
  logic [3:0] nd_mayor;

  modport master (output nd_a, output nd_b, output nd_valid, input nd_mayor);
  modport slave  (input nd_a, input nd_b, input nd_valid, output nd_mayor);
endinterface

// File: rtl/nibble_mayor_driver.sv
// Built-in stimulus engine and checker for the 2-input nibble-max comparator.
// On start it presents all 256 (a, b) pairs (a-major, b-minor), one per clock,
// compares each returned result against max(a, b) LATENCY+1 edges after the
// pair went out, and reports a mismatch count, a pass flag and the first
// failing pair.
//
// Ports:
//   clk          rising-edge clock
//   reset_L      asynchronous active-low reset
//   start        begins a sweep (honoured only in IDLE and DONE)
//   nd           comparator bus (master side): nd_a, nd_b, nd_valid out, nd_mayor in
//   busy         high while sweeping or draining
//   done         level, high once the last pair has been checked
//   pass         done with zero mismatches
//   err_count    mismatches in the current sweep (saturating)
//   first_err_a  a of the first mismatching pair
//   first_err_b  b of the first mismatching pair
//   first_err_v  first_err_a/b hold a captured pair
module nibble_mayor_driver #(
  parameter int LATENCY = 1,
  parameter int ERR_W   = 9
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic                     start,
  nibble_mayor_driver_if.master    nd,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_W-1:0]         err_count,
  output logic [3:0]               first_err_a,
  output logic [3:0]               first_err_b,
  output logic                     first_err_v
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state_q, state_d;

  // {a, b} of the pair currently presented; doubles as the sweep index k.
  logic [7:0] pair_q;
  logic       nd_valid_q;
  logic       sweep_start;

  // Entry leaving the expected-value pipeline on this edge.
  logic       chk_vld;
  logic [3:0] chk_exp;
  logic [7:0] chk_pair;
  logic       mismatch;
  logic       chk_last;

  function automatic logic [3:0] max4(input logic [3:0] x, input logic [3:0] y);
    return (x >= y) ? x : y;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cnt);
    if (&cnt) return cnt;
    return cnt + {{(ERR_W-1){1'b0}}, 1'b1};
  endfunction

  // Stage 0: the pair on the bus right now. A registered comparator of depth
  // LATENCY returns pair k's result just before edge k+LATENCY+1, so the
  // expected value is delayed LATENCY more edges before it meets nd_mayor.
  generate
    if (LATENCY == 0) begin : g_comb
      assign chk_vld  = nd_valid_q;
      assign chk_exp  = max4(pair_q[7:4], pair_q[3:0]);
      assign chk_pair = pair_q;
    end else begin : g_pipe
      logic       vld_p  [LATENCY];
      logic [3:0] exp_p  [LATENCY];
      logic [7:0] pair_p [LATENCY];

      always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
          for (int i = 0; i < LATENCY; i++) begin
            vld_p[i]  <= 1'b0;
            exp_p[i]  <= 4'd0;
            pair_p[i] <= 8'd0;
          end
        end else begin
          vld_p[0]  <= nd_valid_q;
          exp_p[0]  <= max4(pair_q[7:4], pair_q[3:0]);
          pair_p[0] <= pair_q;
          for (int i = 1; i < LATENCY; i++) begin
            vld_p[i]  <= vld_p[i-1];
            exp_p[i]  <= exp_p[i-1];
            pair_p[i] <= pair_p[i-1];
          end
        end
      end

      assign chk_vld  = vld_p[LATENCY-1];
      assign chk_exp  = exp_p[LATENCY-1];
      assign chk_pair = pair_p[LATENCY-1];
    end
  endgenerate

  // nd_mayor is only looked at while a sweep entry is due, so X elsewhere is harmless.
  assign mismatch = chk_vld && (nd.nd_mayor != chk_exp);
  assign chk_last = chk_vld && (chk_pair == 8'hFF);

  // State register
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d     = state_q;
    sweep_start = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sweep_start = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        // With LATENCY=0 the last pair is checked on the same edge it retires.
        if (pair_q == 8'hFF) state_d = chk_last ? DONE : DRAIN;
      end
      DRAIN: begin
        if (chk_last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pair generator and result accumulation
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pair_q      <= 8'd0;
      nd_valid_q  <= 1'b0;
      err_count   <= '0;
      first_err_a <= 4'd0;
      first_err_b <= 4'd0;
      first_err_v <= 1'b0;
    end else if (sweep_start) begin
      pair_q      <= 8'd0;
      nd_valid_q  <= 1'b1;
      err_count   <= '0;
      first_err_a <= 4'd0;
      first_err_b <= 4'd0;
      first_err_v <= 1'b0;
    end else begin
      if (state_q == RUN) begin
        // Hold (15,15) on the bus after the last pair; only valid drops.
        if (pair_q == 8'hFF) nd_valid_q <= 1'b0;
        else                 pair_q     <= pair_q + 8'd1;
      end
      if (mismatch) begin
        err_count <= sat_inc(err_count);
        if (!first_err_v) begin
          first_err_a <= chk_pair[7:4];
          first_err_b <= chk_pair[3:0];
          first_err_v <= 1'b1;
        end
      end
    end
  end

  assign nd.nd_a     = pair_q[7:4];
  assign nd.nd_b     = pair_q[3:0];
  assign nd.nd_valid = nd_valid_q;

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_nibble_mayor_driver.sv
module tb_nibble_mayor_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_L;
  logic start1, start2;

  nibble_mayor_driver_if bus1();
  nibble_mayor_driver_if bus2();

  logic       busy1, done1, pass1, fv1;
  logic [8:0] err1;
  logic [3:0] fa1, fb1;
  logic       busy2, done2, pass2, fv2;
  logic [8:0] err2;
  logic [3:0] fa2, fb2;

  nibble_mayor_driver #(.LATENCY(1), .ERR_W(9)) u_dut1 (
    .clk(clk), .reset_L(reset_L), .start(start1), .nd(bus1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_a(fa1), .first_err_b(fb1), .first_err_v(fv1)
  );

  nibble_mayor_driver #(.LATENCY(2), .ERR_W(9)) u_dut2 (
    .clk(clk), .reset_L(reset_L), .start(start2), .nd(bus2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_err_a(fa2), .first_err_b(fb2), .first_err_v(fv2)
  );

  // Comparator models: mode 0 = max (correct), 1 = min, 2 = stuck-at-0.
  int mode1 = 0, mode2 = 0, stages2 = 1;
  logic [3:0] c1_s1 = 4'd0, c2_s1 = 4'd0, c2_s2 = 4'd0;

  function automatic logic [3:0] cmp_f(input int mode, input logic [3:0] a, input logic [3:0] b);
    case (mode)
      0:       return (a > b) ? a : b;
      1:       return (a < b) ? a : b;
      default: return 4'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    c1_s1 <= cmp_f(mode1, bus1.nd_a, bus1.nd_b);
    c2_s1 <= cmp_f(mode2, bus2.nd_a, bus2.nd_b);
    c2_s2 <= c2_s1;
  end
  assign bus1.nd_mayor = c1_s1;
  assign bus2.nd_mayor = (stages2 == 1) ? c2_s1 : c2_s2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int errs; int pass; int fv; int fa; int fb; int lat; int start_cyc;
  } rep_t;

  rep_t q1[$];
  rep_t q2[$];

  // ---------------- monitors ----------------
  logic done1_q = 1'b0, done2_q = 1'b0;
  rep_t r1, r2;

  always @(negedge clk) begin
    if (done1 && !done1_q) begin
      if (q1.size() == 0) chk("dut1 unexpected done", 1, 0);
      else begin
        r1 = q1.pop_front();
        chk("dut1 err_count", int'(err1), r1.errs);
        chk("dut1 pass", int'(pass1), r1.pass);
        chk("dut1 first_err_v", int'(fv1), r1.fv);
        chk("dut1 first_err_a", int'(fa1), r1.fa);
        chk("dut1 first_err_b", int'(fb1), r1.fb);
        chk("dut1 done latency", cyc - r1.start_cyc, r1.lat);
        chk("dut1 busy in done", int'(busy1), 0);
      end
    end
    done1_q = done1;
  end

  always @(negedge clk) begin
    if (done2 && !done2_q) begin
      if (q2.size() == 0) chk("dut2 unexpected done", 1, 0);
      else begin
        r2 = q2.pop_front();
        chk("dut2 err_count", int'(err2), r2.errs);
        chk("dut2 pass", int'(pass2), r2.pass);
        chk("dut2 first_err_v", int'(fv2), r2.fv);
        chk("dut2 first_err_a", int'(fa2), r2.fa);
        chk("dut2 first_err_b", int'(fb2), r2.fb);
        chk("dut2 done latency", cyc - r2.start_cyc, r2.lat);
      end
    end
    done2_q = done2;
  end

  // Pair order: k-th valid cycle must present (k>>4, k&15).
  int idx1 = 0, idx2 = 0;
  always @(negedge clk) begin
    if (bus1.nd_valid === 1'b1) begin
      chk("dut1 pair order", int'({bus1.nd_a, bus1.nd_b}), idx1);
      idx1++;
    end else idx1 = 0;
    if (bus2.nd_valid === 1'b1) begin
      chk("dut2 pair order", int'({bus2.nd_a, bus2.nd_b}), idx2);
      idx2++;
    end else idx2 = 0;
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; the next posedge is edge 0 of the sweep.
  task automatic run_sweep(input int which, input int errs, input int pass,
                           input int fv, input int fa, input int fb, input int lat);
    rep_t r;
    r.errs = errs; r.pass = pass; r.fv = fv; r.fa = fa; r.fb = fb;
    r.lat = lat; r.start_cyc = cyc;
    if (which == 1) begin q1.push_back(r); start1 = 1'b1; end
    else            begin q2.push_back(r); start2 = 1'b1; end
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input int which);
    int n = 0;
    while (((which == 1) ? done1 : done2) !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("wait for done timeout", int'(n < 400), 1);
  endtask

  task automatic check_idle1(input string tag);
    chk({tag, " nd_a"}, int'(bus1.nd_a), 0);
    chk({tag, " nd_b"}, int'(bus1.nd_b), 0);
    chk({tag, " nd_valid"}, int'(bus1.nd_valid), 0);
    chk({tag, " busy"}, int'(busy1), 0);
    chk({tag, " done"}, int'(done1), 0);
    chk({tag, " pass"}, int'(pass1), 0);
    chk({tag, " err_count"}, int'(err1), 0);
    chk({tag, " first_err_v"}, int'(fv1), 0);
    chk({tag, " first_err_a"}, int'(fa1), 0);
    chk({tag, " first_err_b"}, int'(fb1), 0);
  endtask

  initial begin
    int n;
    reset_L = 1'b0;
    start1  = 1'b0;
    start2  = 1'b0;
    repeat (3) @(negedge clk);
    check_idle1("reset");
    chk("reset dut2 done", int'(done2), 0);
    reset_L = 1'b1;
    @(negedge clk);

    // Correct comparator, with a start pulse mid-RUN that must be ignored.
    mode1 = 0;
    run_sweep(1, 0, 1, 0, 0, 0, 258);
    repeat (20) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("start in RUN ignored busy", int'(busy1), 1);
    wait_done(1);

    // Min comparator: 240 mismatches, first at (0,1). Restart from DONE.
    mode1 = 1;
    run_sweep(1, 240, 0, 1, 0, 1, 258);
    wait_done(1);

    // Stuck-at-0: 255 mismatches, first at (0,1). Restart clears the report at once.
    mode1 = 2;
    run_sweep(1, 255, 0, 1, 0, 1, 258);
    chk("restart done drops", int'(done1), 0);
    chk("restart err_count cleared", int'(err1), 0);
    chk("restart first_err_v cleared", int'(fv1), 0);
    chk("restart busy", int'(busy1), 1);
    wait_done(1);

    // Abort at pair (7,3) with reset, then a clean sweep.
    mode1 = 0;
    run_sweep(1, 0, 1, 0, 0, 0, 258);
    n = 0;
    while (!(bus1.nd_a == 4'd7 && bus1.nd_b == 4'd3) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reach pair (7,3)", int'(n < 300), 1);
    void'(q1.pop_back());
    reset_L = 1'b0;
    #1;
    check_idle1("abort");
    @(negedge clk);
    reset_L = 1'b1;
    @(negedge clk);
    run_sweep(1, 0, 1, 0, 0, 0, 258);
    wait_done(1);

    // LATENCY=2 driver: a 1-stage comparator returns pair k+1's result at
    // pair k's check edge -> 134 mismatches, first at (0,0).
    mode2   = 0;
    stages2 = 1;
    run_sweep(2, 134, 0, 1, 0, 0, 259);
    wait_done(2);

    // Matching 2-stage comparator: clean pass.
    stages2 = 2;
    run_sweep(2, 0, 1, 0, 0, 0, 259);
    wait_done(2);

    repeat (3) @(negedge clk);
    chk("dut1 reports pending", q1.size(), 0);
    chk("dut2 reports pending", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
